// File: rtl/c7b_commit_trace_pkg.sv
// c7b_commit_trace_pkg: shared exception codes and the commit-trace record layout.
package c7b_commit_trace_pkg;

    typedef enum logic [5:0] {
        ECODE_INT  = 6'h00,
        ECODE_PIL  = 6'h01,
        ECODE_PIS  = 6'h02,
        ECODE_PIF  = 6'h03,
        ECODE_PME  = 6'h04,
        ECODE_ADEF = 6'h08,
        ECODE_ALE  = 6'h09,
        ECODE_SYS  = 6'h0b,
        ECODE_BRK  = 6'h0c,
        ECODE_INE  = 6'h0d
    } ecode_e;

    // Record fields above the seq counter, MSB first; the full record is {hdr, seq}.
    typedef struct packed {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exc;
        logic [5:0]  ecode;
    } rec_hdr_t;

    localparam int REC_HDR_W = $bits(rec_hdr_t);

    function automatic int trace_rec_w(input int seq_w);
        return REC_HDR_W + seq_w;
    endfunction

endpackage

// File: rtl/c7b_commit_trace_fifo.sv
// c7b_trace_fifo: generic FIFO with a registered head-of-queue output.
module c7b_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic [AW-1:0]    w_rd_nxt;

    assign w_rd_nxt = r_rd + AW'(pop);
    assign dout     = r_dout;
    assign count    = r_count;
    assign full     = r_count == (AW+1)'(DEPTH);
    assign empty    = r_count == '0;

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr] <= din;
    end

    // The next head is the incoming word whenever it lands in the slot the read pointer moves to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            r_wr    <= r_wr + AW'(push);
            r_rd    <= w_rd_nxt;
            r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
            if (push || pop) r_dout <= (push && r_wr == w_rd_nxt) ? din : r_mem[w_rd_nxt];
        end
    end

endmodule

// File: rtl/c7b_commit_trace.sv
// c7b_commit_trace: captures retired instructions/exceptions and streams them
// in order over a valid/ready trace port, flagging any dropped record.
module c7b_commit_trace
    import c7b_commit_trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_w,
    input  logic [31:0]      pc_w,
    input  logic             rf_wen_w,
    input  logic [4:0]       rf_waddr_w,
    input  logic [31:0]      rf_wdata_w,
    input  logic             exc_w,
    input  logic [5:0]       ecode_w,
    output logic             trace_stall,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic             trace_wen,
    output logic [4:0]       trace_waddr,
    output logic [31:0]      trace_wdata,
    output logic             trace_exc,
    output logic [5:0]       trace_ecode,
    output logic [SEQ_W-1:0] trace_seq,
    output logic             trace_ovf
);
    localparam int REC_W = trace_rec_w(SEQ_W);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [SEQ_W-1:0] r_seq;
    logic             r_ovf;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    rec_hdr_t         w_hdr;
    rec_hdr_t         w_out_hdr;
    logic [REC_W-1:0] w_din;
    logic [REC_W-1:0] w_dout;

    assign w_pop  = trace_valid & trace_ready;
    assign w_push = valid_w & (~w_full | w_pop);

    assign w_hdr = '{
        pc:    pc_w,
        wen:   rf_wen_w & ~exc_w & (rf_waddr_w != 5'd0),
        waddr: rf_waddr_w,
        wdata: rf_wdata_w,
        exc:   exc_w,
        ecode: ecode_w
    };
    assign w_din = {w_hdr, r_seq};

    c7b_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_din),
        .dout   (w_dout),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

    assign {w_out_hdr, trace_seq} = w_dout;
    assign trace_pc    = w_out_hdr.pc;
    assign trace_wen   = w_out_hdr.wen;
    assign trace_waddr = w_out_hdr.waddr;
    assign trace_wdata = w_out_hdr.wdata;
    assign trace_exc   = w_out_hdr.exc;
    assign trace_ecode = w_out_hdr.ecode;
    assign trace_valid = ~w_empty;
    // Stall looks only at the registered count so the core never sees a path from trace_ready.
    assign trace_stall = w_count == CW'(DEPTH);
    assign trace_ovf   = r_ovf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seq <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_seq <= r_seq + SEQ_W'(w_push);
            r_ovf <= r_ovf | (valid_w & ~w_push);
        end
    end

endmodule

// File: tb/tb_c7b_commit_trace.sv
// tb_c7b_commit_trace: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_c7b_commit_trace;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid_w = 1'b0;
    logic [31:0] pc_w = '0;
    logic        rf_wen_w = 1'b0;
    logic [4:0]  rf_waddr_w = '0;
    logic [31:0] rf_wdata_w = '0;
    logic        exc_w = 1'b0;
    logic [5:0]  ecode_w = '0;
    logic        trace_ready = 1'b0;
    logic        trace_stall, trace_valid, trace_wen, trace_exc, trace_ovf;
    logic [31:0] trace_pc, trace_wdata;
    logic [4:0]  trace_waddr;
    logic [5:0]  trace_ecode;
    logic [15:0] trace_seq;

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exc;
        logic [5:0]  ecode;
        logic [15:0] seq;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        mon_e;
    logic [15:0] exp_seq = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    c7b_commit_trace #(.DEPTH(4), .SEQ_W(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid_w     (valid_w),
        .pc_w        (pc_w),
        .rf_wen_w    (rf_wen_w),
        .rf_waddr_w  (rf_waddr_w),
        .rf_wdata_w  (rf_wdata_w),
        .exc_w       (exc_w),
        .ecode_w     (ecode_w),
        .trace_stall (trace_stall),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_wen   (trace_wen),
        .trace_waddr (trace_waddr),
        .trace_wdata (trace_wdata),
        .trace_exc   (trace_exc),
        .trace_ecode (trace_ecode),
        .trace_seq   (trace_seq),
        .trace_ovf   (trace_ovf)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && trace_valid && trace_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_record: got seq %0h expected no record", trace_seq);
            end else begin
                mon_e = exp_q.pop_front();
                chk("record", {trace_pc, trace_wen, trace_waddr, trace_wdata, trace_exc, trace_ecode, trace_seq},
                    {mon_e.pc, mon_e.wen, mon_e.waddr, mon_e.wdata, mon_e.exc, mon_e.ecode, mon_e.seq});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                          input logic exc, input logic [5:0] ec, input logic exp_wen, input bit drop);
        valid_w = 1'b1; pc_w = pc; rf_wen_w = wen; rf_waddr_w = wa; rf_wdata_w = wd; exc_w = exc; ecode_w = ec;
        if (!drop) begin
            exp_q.push_back('{pc, exp_wen, wa, wd, exc, ec, exp_seq});
            exp_seq++;
        end
        @(posedge clk);
        #1;
        valid_w = 1'b0;
    endtask

    initial begin
        idle(2);
        chk("reset_valid", trace_valid, 0);
        chk("reset_stall", trace_stall, 0);
        chk("reset_ovf", trace_ovf, 0);
        chk("reset_pc", trace_pc, 0);
        chk("reset_seq", trace_seq, 0);
        resetn = 1'b1;
        trace_ready = 1'b1;
        idle(1);
        // store (no RF write), then addi r5 <- 0x5a
        retire(32'h1c000024, 1'b0, 5'd0, 32'h0, 1'b0, 6'h00, 1'b0, 0);
        idle(1);
        retire(32'h1c000028, 1'b1, 5'd5, 32'h5a, 1'b0, 6'h00, 1'b1, 0);
        chk("addi_latency_valid", trace_valid, 1);
        chk("addi_pc", trace_pc, 32'h1c000028);
        chk("addi_seq_incr", trace_seq, 16'd1);
        // ALE on misaligned ld.w, then a write to r0
        retire(32'h1c000010, 1'b1, 5'd5, 32'hdeadbeef, 1'b1, 6'h09, 1'b0, 0);
        chk("ale_wen", trace_wen, 0);
        chk("ale_ecode", trace_ecode, 6'h09);
        retire(32'h1c000014, 1'b1, 5'd0, 32'h1234, 1'b0, 6'h00, 1'b0, 0);
        chk("r0_wen", trace_wen, 0);
        chk("r0_wdata", trace_wdata, 32'h1234);
        idle(3);
        // fill, then push and pop together for 8 cycles
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            retire(32'h1c000100 + 32'(4*i), 1'b1, 5'(i+1), 32'(i), 1'b0, 6'h00, 1'b1, 0);
        chk("full_stall", trace_stall, 1);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            retire(32'h1c000200 + 32'(4*i), 1'b1, 5'(i+8), 32'(i+100), 1'b0, 6'h00, 1'b1, 0);
            chk("pushpop_stall", trace_stall, 1);
        end
        chk("pushpop_ovf", trace_ovf, 0);
        idle(8);
        chk("drained_stall", trace_stall, 0);
        chk("drained_valid", trace_valid, 0);
        // backpressure with a dropped fifth record
        trace_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            retire(32'h1c000300 + 32'(4*i), 1'b1, 5'(i+1), 32'(i+200), 1'b0, 6'h00, 1'b1, 0);
        chk("bp_stall", trace_stall, 1);
        chk("bp_ovf_before", trace_ovf, 0);
        retire(32'h1c000310, 1'b1, 5'd9, 32'hbad, 1'b0, 6'h00, 1'b1, 1);
        chk("bp_ovf", trace_ovf, 1);
        chk("bp_stall_hold", trace_stall, 1);
        trace_ready = 1'b1;
        idle(1);
        chk("bp_stall_release", trace_stall, 0);
        idle(6);
        chk("bp_ovf_sticky", trace_ovf, 1);
        // reset with three records queued
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            retire(32'h1c000400 + 32'(4*i), 1'b1, 5'(i+1), 32'(i), 1'b0, 6'h00, 1'b1, 0);
        chk("pre_reset_valid", trace_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_valid", trace_valid, 0);
        chk("async_reset_stall", trace_stall, 0);
        chk("async_reset_ovf", trace_ovf, 0);
        exp_q.delete();
        exp_seq = '0;
        idle(1);
        resetn = 1'b1;
        trace_ready = 1'b1;
        retire(32'h1c000500, 1'b1, 5'd7, 32'h77, 1'b0, 6'h00, 1'b1, 0);
        chk("post_reset_seq", trace_seq, 16'd0);
        // walk seq to 0xFFFF and wrap
        while (exp_seq != 16'hffff)
            retire({16'h1c01, exp_seq}, 1'b1, 5'd3, {16'h0, exp_seq}, 1'b0, 6'h00, 1'b1, 0);
        retire(32'h1c00fff0, 1'b1, 5'd4, 32'hffff, 1'b0, 6'h00, 1'b1, 0);
        chk("seq_ffff", trace_seq, 16'hffff);
        retire(32'h1c00fff4, 1'b1, 5'd4, 32'h0, 1'b0, 6'h00, 1'b1, 0);
        chk("seq_wrap", trace_seq, 16'h0000);
        idle(3);
        chk("final_ovf", trace_ovf, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/c7b_commit_trace.md
# c7b_commit_trace

Commit-trace transmitter for the c7b core. It sits beside the writeback stage of `u_exu` and captures every retired instruction or exception into a small FIFO. It then transmits one record per transfer over a valid/ready trace port to an external checker or trace sink. This replaces hierarchical probing of `pc_w` and `u_rf.regs[]` with a defined, synthesizable interface.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `SEQ_W`, 16: width of the retire sequence counter.
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `valid_w` in 1: writeback stage retires a record this cycle.
- `pc_w` in 32: PC of the retiring instruction.
- `rf_wen_w` in 1: register-file write enable.
- `rf_waddr_w` in 5: destination register.
- `rf_wdata_w` in 32: write data.
- `exc_w` in 1: the instruction raised an exception (no RF write).
- `ecode_w` in 6: exception code; ALE = 6'h09.
- `trace_stall` out 1: FIFO full; the core must hold retirement.
- `trace_valid` out 1: record available.
- `trace_ready` in 1: sink accepts the record.
- `trace_pc` out 32, `trace_wen` out 1, `trace_waddr` out 5, `trace_wdata` out 32, `trace_exc` out 1, `trace_ecode` out 6, `trace_seq` out SEQ_W: record fields.
- `trace_ovf` out 1: sticky flag, set when a record was dropped.

## Operation
- Push condition: `valid_w` and the FIFO has a free slot, or the FIFO is full and a pop occurs in the same cycle.
- Pop condition: `trace_valid & trace_ready`.
- Record contents: {pc, wen, waddr, wdata, exc, ecode, seq}.
- `wen` field = `rf_wen_w & ~exc_w & (rf_waddr_w != 0)`. Writes to r0 and excepting instructions are reported with wen=0. `waddr` and `wdata` are still passed through unchanged.
- `seq` = value of the internal counter at push. The counter increments only on accepted pushes and wraps from 2^SEQ_W−1 to 0.
- When `valid_w` arrives and the push condition fails, the record is dropped: `trace_ovf` sets, `seq` does not increment, and FIFO contents are unchanged. `trace_ovf` clears only on reset.
- `trace_stall` = (count == DEPTH). It is combinational from registered count only and has no path from `trace_ready`.
- While `trace_valid=1` and `trace_ready=0`, all `trace_*` record fields hold stable.
- Record ordering is strictly FIFO; no reordering and no merging.

## Timing
- Reset values: `trace_valid=0`, `trace_stall=0`, `trace_ovf=0`, seq counter=0, count=0, read/write pointers=0. Record outputs are 0 at reset; they are don't-care while `trace_valid=0`.
- Latency: a record pushed at edge N is on `trace_*` with `trace_valid=1` after edge N. There is no same-cycle bypass; minimum latency is 1 cycle.
- Throughput: 1 record/cycle with `trace_ready` held high.
- Empty with push and no pop: count becomes 1, and `trace_valid` rises the next cycle.
- Full with push and pop in the same cycle: both occur, count stays DEPTH, and the pointers advance and wrap modulo DEPTH.
- Full with push and no pop: the record is dropped and `trace_ovf` is 1 from the next cycle.
- Reset asserted mid-stream: the FIFO flushes immediately (asynchronously). In-flight records are lost and are not reported as overflow.
- Count uses log2(DEPTH)+1 bits. Pointers use log2(DEPTH) bits with natural wrap.

## Structure
- Defines in `defines.vh`:
  - `` `TRACE_REC_W`` = 77+SEQ_W.
  - `` `ECODE_ALE`` = 6'h09, plus the other ecode constants shared with `u_exu`.
  - Record field offsets.
- Sub-module `c7b_trace_fifo`:
  - Generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Signals: push, pop, din, dout, count, full, empty.
  - Registered read data.
- `c7b_commit_trace` contains the record packing, the wen masking, the seq counter, the overflow flag and the stall logic.
- Instantiated in `u_core` next to `u_exu`. Tie `trace_ready=1` when no sink is present.

## Test plan
- Single store, then `addi r5 ← 0x5a` retiring at pc 0x1c000028 with `trace_ready=1`:
  - exactly one record with pc=0x1c000028, wen=1, waddr=5, wdata=0x5a, exc=0;
  - it appears 1 cycle after `valid_w`;
  - seq increments between records.
- Misaligned `ld.w` raising ALE at pc 0x1c000010 (`exc_w=1`, `ecode_w=0x09`, `rf_wen_w=1`, waddr=5): record has exc=1, ecode=0x09, wen=0.
- Write to r0 (waddr=0, wdata=0x1234, wen=1): record has wen=0, waddr=0, wdata=0x1234.
- Backpressure, `trace_ready=0`, 4 pushes with DEPTH=4:
  - `trace_stall=1` after the 4th push;
  - a 5th `valid_w` is dropped and `trace_ovf`=1;
  - on releasing ready, records drain in order with seq 0,1,2,3 and the stall deasserts after the first pop.
- Full FIFO with simultaneous push and pop for 8 cycles: no drops, `trace_ovf` stays 0, and output seq is contiguous across the pointer wrap.
- Set the seq counter to 0xFFFF by forced push count, then push 2 records: seq 0xFFFF then 0x0000.
- Reset mid-stream: deassert `resetn` with 3 records queued; `trace_valid=0` and count=0 immediately, and the first record after reset has seq=0.
